// File: rtl/sc_lanectrl.sv
// rtl/sc_lanectrl.sv - lane register controller: load, verify and rotate a vehicle bitmap
// Keeps a mirror of the downstream lane register and cross-checks it via LOADED.
module sc_lanectrl #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int PERIOD_WIDTH  = 16
) (
  input  logic                     SC_LANECTRL_CLOCK,
  input  logic                     SC_LANECTRL_RESET,
  input  logic                     SC_LANECTRL_START,
  input  logic                     SC_LANECTRL_STOP,
  input  logic                     SC_LANECTRL_PAUSE,
  input  logic [PERIOD_WIDTH-1:0]  SC_LANECTRL_PERIOD,
  input  logic [DATAWIDTH_BUS-1:0] SC_LANECTRL_PATTERN_IN,
  input  logic                     SC_LANECTRL_LOADED,
  output logic                     SC_LANECTRL_LOAD,
  output logic                     SC_LANECTRL_SHIFT,
  output logic [DATAWIDTH_BUS-1:0] SC_LANECTRL_PATTERN_OUT,
  output logic                     SC_LANECTRL_WRAP,
  output logic                     SC_LANECTRL_BUSY,
  output logic                     SC_LANECTRL_ERROR
);

  localparam int CW = (DATAWIDTH_BUS > 1) ? $clog2(DATAWIDTH_BUS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOADP, S_VERIFY, S_RUN, S_ERROR
  } state_t;

  state_t                   state;
  logic [DATAWIDTH_BUS-1:0] mirror;
  logic [PERIOD_WIDTH-1:0]  presc;
  logic [PERIOD_WIDTH-1:0]  period_m1;
  logic [CW-1:0]            step_cnt;
  logic                     first_run;
  logic                     wrap_q;
  logic                     step;

  // PERIOD of 0 behaves like 1: step every cycle.
  assign period_m1 = (SC_LANECTRL_PERIOD == '0) ? '0
                   : SC_LANECTRL_PERIOD - PERIOD_WIDTH'(1);

  // START/STOP override stepping so the lane register never rotates without the mirror.
  assign step = (state == S_RUN) && !SC_LANECTRL_PAUSE && !SC_LANECTRL_STOP &&
                !SC_LANECTRL_START && (presc >= period_m1);

  assign SC_LANECTRL_SHIFT       = step;
  assign SC_LANECTRL_LOAD        = (state == S_LOADP) || (state == S_VERIFY) ||
                                   ((state == S_RUN) && !step);
  assign SC_LANECTRL_PATTERN_OUT = mirror;
  assign SC_LANECTRL_WRAP        = wrap_q;
  assign SC_LANECTRL_BUSY        = (state == S_LOADP) || (state == S_VERIFY) ||
                                   (state == S_RUN);
  assign SC_LANECTRL_ERROR       = (state == S_ERROR);

  always_ff @(posedge SC_LANECTRL_CLOCK or posedge SC_LANECTRL_RESET) begin
    if (SC_LANECTRL_RESET) begin
      state     <= S_IDLE;
      mirror    <= '0;
      presc     <= '0;
      step_cnt  <= '0;
      first_run <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (SC_LANECTRL_STOP) begin
        state     <= S_IDLE;
        mirror    <= '0;
        presc     <= '0;
        step_cnt  <= '0;
        first_run <= 1'b0;
      end else if (SC_LANECTRL_START) begin
        state     <= S_LOADP;
        mirror    <= SC_LANECTRL_PATTERN_IN;
        presc     <= '0;
        step_cnt  <= '0;
        first_run <= 1'b0;
      end else begin
        case (state)
          S_IDLE:   mirror <= '0;
          S_LOADP:  state <= S_VERIFY;
          S_VERIFY: begin
            if (SC_LANECTRL_LOADED) begin
              state     <= S_RUN;
              presc     <= '0;
              first_run <= 1'b1;
            end else begin
              state <= S_ERROR;
            end
          end
          S_RUN: begin
            first_run <= 1'b0;
            if (!SC_LANECTRL_LOADED && !(first_run && step)) begin
              state <= S_ERROR;
            end else if (step) begin
              mirror <= {mirror[DATAWIDTH_BUS-2:0], mirror[DATAWIDTH_BUS-1]};
              presc  <= '0;
              if (step_cnt == CW'(DATAWIDTH_BUS - 1)) begin
                step_cnt <= '0;
                wrap_q   <= 1'b1;
              end else begin
                step_cnt <= step_cnt + CW'(1);
              end
            end else if (!SC_LANECTRL_PAUSE) begin
              presc <= presc + PERIOD_WIDTH'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sc_lanectrl.sv
// tb/tb_sc_lanectrl.sv - directed bench for sc_lanectrl with a modelled lane register
module tb_sc_lanectrl;

  typedef struct {
    logic        start;
    logic        stop;
    logic        pause;
    logic [15:0] period;
    logic [7:0]  pattern;
    logic [12:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] period = 16'd4;
  logic [7:0]  pat_in = 8'h00;
  logic        loaded;
  logic        load, shift, wrap, busy, err;
  logic [7:0]  pat_out;
  logic [7:0]  lane;
  logic        force_bad = 1'b0;
  logic [12:0] o;
  int          tests = 0;
  int          fails = 0;
  vec_t        vecs[12];

  sc_lanectrl #(.DATAWIDTH_BUS(8), .PERIOD_WIDTH(16)) dut (
    .SC_LANECTRL_CLOCK       (clk),
    .SC_LANECTRL_RESET       (rst),
    .SC_LANECTRL_START       (start),
    .SC_LANECTRL_STOP        (stop),
    .SC_LANECTRL_PAUSE       (pause),
    .SC_LANECTRL_PERIOD      (period),
    .SC_LANECTRL_PATTERN_IN  (pat_in),
    .SC_LANECTRL_LOADED      (loaded),
    .SC_LANECTRL_LOAD        (load),
    .SC_LANECTRL_SHIFT       (shift),
    .SC_LANECTRL_PATTERN_OUT (pat_out),
    .SC_LANECTRL_WRAP        (wrap),
    .SC_LANECTRL_BUSY        (busy),
    .SC_LANECTRL_ERROR       (err)
  );

  always #5 clk = ~clk;

  // Downstream lane register
  always @(posedge clk or posedge rst) begin
    if (rst)        lane <= 8'h00;
    else if (load)  lane <= pat_out;
    else if (shift) lane <= {lane[6:0], lane[7]};
  end

  assign loaded = (lane == pat_out) && !force_bad;
  assign o = {load, shift, wrap, busy, err, pat_out};

  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      if (load && shift) begin
        fails++;
        $display("FAIL load_shift_exclusive: load=%b shift=%b, required not both high", load, shift);
      end
    end
  end

  function automatic vec_t mk(logic st, logic sp, logic pa, logic [15:0] per, logic [7:0] pin,
                              logic l, logic s, logic w, logic b, logic e, logic [7:0] p);
    vec_t v;
    v.start = st; v.stop = sp; v.pause = pa; v.period = per; v.pattern = pin;
    v.exp = {l, s, w, b, e, p};
    return v;
  endfunction

  task automatic chk(input string name, input logic [12:0] exp);
    tests++;
    if (o !== exp)
      begin
        fails++;
        $display("FAIL %s: got {load,shift,wrap,busy,err,pat}=%b_%h required %b_%h",
                 name, o[12:8], o[7:0], exp[12:8], exp[7:0]);
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 0, 4, 8'h81, 0, 0, 0, 0, 0, 8'h00);
    vecs[1]  = mk(0, 0, 0, 4, 8'h81, 1, 0, 0, 1, 0, 8'h81);
    vecs[2]  = mk(0, 0, 0, 4, 8'h81, 1, 0, 0, 1, 0, 8'h81);
    vecs[3]  = mk(0, 0, 0, 4, 8'h81, 1, 0, 0, 1, 0, 8'h81);
    vecs[4]  = mk(0, 0, 0, 4, 8'h81, 1, 0, 0, 1, 0, 8'h81);
    vecs[5]  = mk(0, 0, 0, 4, 8'h81, 1, 0, 0, 1, 0, 8'h81);
    vecs[6]  = mk(0, 0, 0, 4, 8'h81, 0, 1, 0, 1, 0, 8'h81);
    vecs[7]  = mk(0, 0, 0, 4, 8'h81, 1, 0, 0, 1, 0, 8'h03);
    vecs[8]  = mk(0, 0, 0, 4, 8'h81, 1, 0, 0, 1, 0, 8'h03);
    vecs[9]  = mk(0, 0, 0, 4, 8'h81, 1, 0, 0, 1, 0, 8'h03);
    vecs[10] = mk(0, 0, 0, 4, 8'h81, 0, 1, 0, 1, 0, 8'h03);
    vecs[11] = mk(0, 0, 0, 4, 8'h81, 1, 0, 0, 1, 0, 8'h06);

    #2;
    chk("reset_state", 13'h0);
    cyc();
    rst = 1'b0;

    // Period-4 run of 0x81
    for (int i = 0; i < 12; i++) begin
      cyc();
      start = vecs[i].start; stop = vecs[i].stop; pause = vecs[i].pause;
      period = vecs[i].period; pat_in = vecs[i].pattern;
      #3;
      chk($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Period 1: eight back-to-back steps, then WRAP
    cyc(); stop = 1'b1;
    cyc(); stop = 1'b0; start = 1'b1; pat_in = 8'h01; period = 16'd1;
    cyc(); start = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      cyc(); #3;
      chk($sformatf("p1_step%0d", i), {5'b01010, 8'(8'h01 << i)});
    end
    cyc(); #3; chk("wrap_pulse", {5'b01110, 8'h01});
    cyc(); #3; chk("wrap_single", {5'b01010, 8'h02});

    // Pause for ten cycles holds the prescaler
    cyc(); stop = 1'b1;
    cyc(); stop = 1'b0; start = 1'b1; pat_in = 8'h81; period = 16'd4;
    cyc(); start = 1'b0;
    cyc();
    cyc(); #3; chk("pause_pre", {5'b10010, 8'h81});
    for (int i = 0; i < 10; i++) begin
      cyc(); pause = 1'b1; #3;
      chk($sformatf("pause%0d", i), {5'b10010, 8'h81});
    end
    cyc(); pause = 1'b0; #3; chk("resume_p1", {5'b10010, 8'h81});
    cyc(); #3; chk("resume_p2", {5'b10010, 8'h81});
    cyc(); #3; chk("resume_step", {5'b01010, 8'h81});
    cyc(); #3; chk("resume_after", {5'b10010, 8'h03});

    // LOADED low in VERIFY, then recovery with 0x55
    cyc(); stop = 1'b1;
    cyc(); stop = 1'b0; start = 1'b1; pat_in = 8'h3C;
    cyc(); start = 1'b0; #3; chk("err_loadp", {5'b10010, 8'h3C});
    cyc(); force_bad = 1'b1; #3; chk("err_verify", {5'b10010, 8'h3C});
    cyc(); force_bad = 1'b0; #3; chk("err_state", {5'b00001, 8'h3C});
    cyc(); #3; chk("err_hold", {5'b00001, 8'h3C});
    cyc(); start = 1'b1; pat_in = 8'h55; #3; chk("err_start", {5'b00001, 8'h3C});
    cyc(); start = 1'b0; #3; chk("rec_loadp", {5'b10010, 8'h55});
    cyc(); #3; chk("rec_verify", {5'b10010, 8'h55});
    cyc(); #3; chk("rec_run", {5'b10010, 8'h55});
    cyc(); period = 16'd0; #3; chk("period0_step", {5'b01010, 8'h55});
    cyc(); #3; chk("period0_step2", {5'b01010, 8'hAA});

    // START and STOP together in RUN
    cyc(); start = 1'b1; stop = 1'b1; #3; chk("startstop_cycle", {5'b10010, 8'h55});
    cyc(); start = 1'b0; stop = 1'b0; #3; chk("startstop_idle", 13'h0);

    // Asynchronous reset on a step cycle
    cyc(); start = 1'b1; pat_in = 8'h0F; period = 16'd2;
    cyc(); start = 1'b0;
    cyc();
    cyc(); #3; chk("rst_run_pre", {5'b10010, 8'h0F});
    cyc(); #3; chk("rst_step", {5'b01010, 8'h0F});
    #1 rst = 1'b1;
    #1 chk("rst_async", 13'h0);
    cyc();
    cyc(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(); #3;
      chk($sformatf("post_rst%0d", i), 13'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
